shift_sub_divider: RTL and testbench

//  Sequential unsigned restoring divider; the inverse of the add-shift multiplier.
//  FSM plus datapath in one block: shift remainder/quotient pair, test, conditionally subtract.

---
 rtl/shift_sub_divider.sv | 116 +++++++++++
 tb/tb_shift_sub_divider.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider: one quotient bit per SHIFT/TEST(/SUB) pass.
// Shares the st/done start-finish handshake with the add-shift multiplier.
module shift_sub_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  // state  | meaning
  // IDLE   | waiting for st; operands captured on the accepting edge
  // SHIFT  | shift {r,q} left one bit, count the iteration
  // TEST   | compare partial remainder against divisor
  // SUB    | subtract divisor, set quotient lsb
  // FINISH | results valid, done pulse for one cycle

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N);

  typedef enum logic [2:0] {IDLE, SHIFT, TEST, SUB, FINISH} state_t;

  state_t        state, state_nxt;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;
  logic [N:0]    r_sub;
  logic          r_ge_d;
  logic          last_iter;

  assign r_sub     = r - {1'b0, d};
  assign r_ge_d    = (r >= {1'b0, d});
  assign last_iter = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (st) state_nxt = (divisor == '0) ? FINISH : SHIFT;
      SHIFT:   state_nxt = TEST;
      TEST:    if (r_ge_d)         state_nxt = SUB;
               else if (last_iter) state_nxt = FINISH;
               else                state_nxt = SHIFT;
      SUB:     state_nxt = last_iter ? FINISH : SHIFT;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (st && divisor != '0) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= '0;
          end else if (st) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        SHIFT: begin
          {r, q} <= {r[N-1:0], q, 1'b0};
          cnt    <= cnt + CW'(1);
        end
        TEST: begin
          if (!r_ge_d && last_iter) begin
            quotient    <= q;
            remainder   <= r[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        SUB: begin
          r    <= r_sub;
          q[0] <= 1'b1;
          // Results on the final pass must see the post-subtract values.
          if (last_iter) begin
            quotient    <= {q[N-1:1], 1'b1};
            remainder   <= r_sub[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: driver pushes expected results,
// monitor pops and checks result, flag and latency on every done pulse.
module tb_shift_sub_divider;

  localparam int N = 32;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           acc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         st = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int   ntests = 0;
  int   nfail = 0;
  int   cyc = 0;
  exp_t sb[$];

  logic [N-1:0] lq = '0, lr = '0;
  logic         lz = 1'b0;
  bit           unstable = 1'b0;

  shift_sub_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .st(st), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      lq = '0; lr = '0; lz = 1'b0; unstable = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(quotient), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", 64'(quotient), 64'(e.q));
        chk("remainder", 64'(remainder), 64'(e.r));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.z));
        chk("done_latency", 64'(cyc - e.acc), 64'(e.lat));
        chk("hold_stable", 64'(unstable), 64'd0);
      end
      lq = quotient; lr = remainder; lz = div_by_zero; unstable = 1'b0;
    end else if ({quotient, remainder, div_by_zero} !== {lq, lr, lz}) begin
      unstable = 1'b1;
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input bit hold);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (busy && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      chk("issue_timeout", 64'(busy), 64'd0);
      return;
    end
    dividend = a;
    divisor  = b;
    st       = 1'b1;
    e.q   = eq;
    e.r   = er;
    e.z   = (b == '0);
    e.acc = cyc + 1;
    e.lat = (b == '0) ? 0 : 2 * N + $countones(eq);
    sb.push_back(e);
    @(negedge clk);
    if (!hold) st = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic issue_model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) issue(a, b, '1, a, 1'b0);
    else         issue(a, b, a / b, a % b, 1'b0);
  endtask

  initial begin
    logic [N-1:0] a, b;
    int w;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_outputs", 64'({quotient, remainder, busy, done, div_by_zero} == '0), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    chk("dbz_busy_one_cycle", 64'(busy), 64'd1);
    @(negedge clk);
    chk("dbz_busy_cleared", 64'(busy), 64'd0);
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
    issue(32'd7, 32'd7, 32'd1, 32'd0, 1'b0);
    issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    issue(32'h1234_5678, 32'h1_0000, 32'h1234, 32'h5678, 1'b0);

    // ST pulse mid-divide must be ignored
    issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
    repeat (18) @(negedge clk);
    dividend = 32'd9; divisor = 32'd3; st = 1'b1;
    @(negedge clk);
    st = 1'b0;

    // back-to-back with st held high
    issue(32'd20, 32'd4, 32'd5, 32'd0, 1'b1);
    issue(32'd9, 32'd2, 32'd4, 32'd1, 1'b1);
    issue(32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(32'd13, 32'd5, 32'd2, 32'd3, 1'b0);

    // reset mid-divide abandons the operation
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (28) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 64'({quotient, remainder, busy, done, div_by_zero} == '0), 64'd1);
    sb.delete();
    st = 1'b1;
    dividend = 32'd40; divisor = 32'd4;
    @(negedge clk);
    st = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("st_during_reset_ignored", 64'(busy), 64'd0);
    issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 255));
        2: b = a;
        default: b = a | 32'h8000_0000;
      endcase
      if (i % 8 == 5) a = a | 32'h8000_0000;
      issue_model(a, b);
    end

    w = 0;
    while ((sb.size() != 0 || busy) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
